multiword_add_sequencer: RTL and testbench

//   Adds two WORDS*N-bit operands over WORDS cycles through one shared N-bit FullAdderN #(.n(N)),
//   one word per cycle, least-significant word first.
//   A registered carry links consecutive words.

---
 rtl/multiword_add_sequencer_if.sv | 25 ++
 rtl/multiword_add_sequencer.sv | 100 ++++++++++
 tb/tb_multiword_add_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/multiword_add_sequencer_if.sv
// multiword_add_sequencer_if: start/operand/result bundle for the word-serial adder (Sub only with MWADD_SUB_EN)
interface multiword_add_sequencer_if #(
    parameter int N     = 8,
    parameter int WORDS = 4
);
    logic               Start;
    logic [N*WORDS-1:0] X;
    logic [N*WORDS-1:0] Y;
    logic               CarryIn;
`ifdef MWADD_SUB_EN
    logic               Sub;
`endif
    logic               Busy;
    logic               Done;
    logic [N*WORDS-1:0] Sum;
    logic               CarryOut;

`ifdef MWADD_SUB_EN
    modport master (output Start, X, Y, CarryIn, Sub, input Busy, Done, Sum, CarryOut);
    modport slave  (input Start, X, Y, CarryIn, Sub, output Busy, Done, Sum, CarryOut);
`else
    modport master (output Start, X, Y, CarryIn, input Busy, Done, Sum, CarryOut);
    modport slave  (input Start, X, Y, CarryIn, output Busy, Done, Sum, CarryOut);
`endif
endinterface

// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer: WORDS*N-bit add over WORDS cycles through one N-bit adder; MWADD_SUB_EN adds X-Y mode
module FullAdderN #(
    parameter int n = 8
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cIn,
    output logic [n-1:0] s,
    output logic         cOut
);
    assign {cOut, s} = a + b + {{n{1'b0}}, cIn};
endmodule

module multiword_add_sequencer #(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input logic Clock,
    input logic Reset,
    multiword_add_sequencer_if.slave bus
);
    localparam int W  = N * WORDS;
    localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, nextState;
    logic [W-1:0]  xReg, yReg, sumReg;
    logic [IW-1:0] idx;
    logic          carry, carryOut, initCarry;
    logic [N-1:0]  bWord, sWord;
    logic          cWord;

`ifdef MWADD_SUB_EN
    logic subReg;
    assign bWord     = subReg ? ~yReg[idx*N +: N] : yReg[idx*N +: N];
    assign initCarry = bus.Sub | bus.CarryIn;
`else
    assign bWord     = yReg[idx*N +: N];
    assign initCarry = bus.CarryIn;
`endif

    FullAdderN #(.n(N)) adder (
        .a   (xReg[idx*N +: N]),
        .b   (bWord),
        .cIn (carry),
        .s   (sWord),
        .cOut(cWord)
    );

    assign bus.Busy     = state == RUN;
    assign bus.Done     = state == DONE;
    assign bus.Sum      = sumReg;
    assign bus.CarryOut = carryOut;

    // state register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= nextState;
    end

    // next state: accept in IDLE, step words in RUN, single DONE cycle
    always_comb begin
        nextState = IDLE;
        case (state)
            IDLE:    nextState = bus.Start ? RUN : IDLE;
            RUN:     nextState = idx == LAST ? DONE : RUN;
            default: nextState = IDLE;
        endcase
    end

    // operand capture on accept, then one result word and carry per RUN cycle
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            xReg     <= '0;
            yReg     <= '0;
            sumReg   <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            carryOut <= 1'b0;
`ifdef MWADD_SUB_EN
            subReg   <= 1'b0;
`endif
        end else if (state == IDLE && bus.Start) begin
            xReg  <= bus.X;
            yReg  <= bus.Y;
            idx   <= '0;
            carry <= initCarry;
`ifdef MWADD_SUB_EN
            subReg <= bus.Sub;
`endif
        end else if (state == RUN) begin
            sumReg[idx*N +: N] <= sWord;
            carry              <= cWord;
            if (idx == LAST) carryOut <= cWord;
            else             idx      <= idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// tb_multiword_add_sequencer: vector table, hand-written timing/abort sequences and random ops against an arithmetic model
module tb_multiword_add_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    multiword_add_sequencer_if #(.N(8), .WORDS(4)) bus ();
    multiword_add_sequencer_if #(.N(8), .WORDS(1)) bus1 ();

    multiword_add_sequencer #(.N(8), .WORDS(4)) dut (.Clock(clock), .Reset(reset), .bus(bus.slave));
    multiword_add_sequencer #(.N(8), .WORDS(1)) dut1 (.Clock(clock), .Reset(reset), .bus(bus1.slave));

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        cin;
        logic [31:0] s;
        logic        co;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // one op on the 4-word DUT; lat counts negedges from accept to Done (20 means timeout)
    task automatic runOp(input logic [31:0] x, input logic [31:0] y, input logic cin,
                         output logic [31:0] s, output logic co, output int lat);
        @(negedge clock);
        bus.X = x;
        bus.Y = y;
        bus.CarryIn = cin;
        bus.Start = 1'b1;
        @(negedge clock);
        bus.Start = 1'b0;
        lat = 1;
        while (!bus.Done && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        s = bus.Sum;
        co = bus.CarryOut;
    endtask

    vec_t tbl[8];
    vec_t subTbl[3];

    initial begin
        logic [31:0] s, x, y;
        logic co, cin, sub, sawDone;
        logic [32:0] expAdd;
        logic [8:0] exp8;
        logic [7:0] x8, y8;
        int lat;

        tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
        tbl[1] = '{32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0};
        tbl[2] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
        tbl[3] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0};
        tbl[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
        tbl[5] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0};
        tbl[6] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
        tbl[7] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0};
        subTbl[0] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0};
        subTbl[1] = '{32'h00000007, 32'h00000005, 1'b0, 32'h00000002, 1'b1};
        subTbl[2] = '{32'h00000009, 32'h00000009, 1'b0, 32'h00000000, 1'b1};

        bus.Start = 1'b0; bus.X = '0; bus.Y = '0; bus.CarryIn = 1'b0;
        bus1.Start = 1'b0; bus1.X = '0; bus1.Y = '0; bus1.CarryIn = 1'b0;
`ifdef MWADD_SUB_EN
        bus.Sub = 1'b0;
        bus1.Sub = 1'b0;
`endif

        repeat (2) @(negedge clock);
        check("reset Busy", bus.Busy, 0);
        check("reset Done", bus.Done, 0);
        check("reset Sum", bus.Sum, 0);
        check("reset CarryOut", bus.CarryOut, 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Busy/Done timeline for a wrapping add
        bus.X = 32'hFFFFFFFF; bus.Y = 32'h1; bus.CarryIn = 1'b0; bus.Start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            bus.Start = 1'b0;
            check($sformatf("timeline Busy k=%0d", k), bus.Busy, k <= 4);
            check($sformatf("timeline Done k=%0d", k), bus.Done, k == 5);
        end
        check("timeline Sum", bus.Sum, 32'h0);
        check("timeline CarryOut", bus.CarryOut, 1);
        @(negedge clock);
        check("timeline Done once", bus.Done, 0);

        for (int i = 0; i < 8; i++) begin
            runOp(tbl[i].x, tbl[i].y, tbl[i].cin, s, co, lat);
            check($sformatf("tbl[%0d] latency", i), lat, 5);
            check($sformatf("tbl[%0d] Sum", i), s, tbl[i].s);
            check($sformatf("tbl[%0d] CarryOut", i), co, tbl[i].co);
            @(negedge clock);
            check($sformatf("tbl[%0d] Done once", i), bus.Done, 0);
        end

        // Start held high through RUN/DONE with changing operands
        repeat (2) @(negedge clock);
        bus.X = 32'h12345678; bus.Y = 32'h11111111; bus.CarryIn = 1'b1; bus.Start = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clock);
            if (k == 1) begin
                bus.X = '0; bus.Y = '0; bus.CarryIn = 1'b0;
            end
            if (k == 5) begin
                check("held Done", bus.Done, 1);
                check("held Sum", bus.Sum, 32'h2345678A);
                check("held CarryOut", bus.CarryOut, 0);
            end
            if (k == 6) begin
                check("held idle Busy", bus.Busy, 0);
                check("held idle Sum", bus.Sum, 32'h2345678A);
            end
            if (k == 7) check("held restart Busy", bus.Busy, 1);
        end
        bus.Start = 1'b0;
        lat = 1;
        while (!bus.Done && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check("held second latency", lat, 5);
        check("held second Sum", bus.Sum, 32'h0);

        // reset during the second RUN cycle aborts the op
        repeat (2) @(negedge clock);
        bus.X = 32'h01020304; bus.Y = 32'h10101010; bus.CarryIn = 1'b1; bus.Start = 1'b1;
        @(negedge clock);
        bus.Start = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("abort Busy", bus.Busy, 0);
        check("abort Sum", bus.Sum, 0);
        check("abort CarryOut", bus.CarryOut, 0);
        #2 reset = 1'b0;
        sawDone = 1'b0;
        repeat (8) begin
            @(negedge clock);
            sawDone |= bus.Done;
        end
        check("abort no Done", sawDone, 0);
        runOp(32'h1, 32'h2, 1'b0, s, co, lat);
        check("after abort latency", lat, 5);
        check("after abort Sum", s, 32'h3);

`ifdef MWADD_SUB_EN
        bus.Sub = 1'b1;
        for (int i = 0; i < 3; i++) begin
            runOp(subTbl[i].x, subTbl[i].y, subTbl[i].cin, s, co, lat);
            check($sformatf("sub[%0d] Sum", i), s, subTbl[i].s);
            check($sformatf("sub[%0d] CarryOut", i), co, subTbl[i].co);
        end
        bus.Sub = 1'b0;
`endif

        // random ops against plain arithmetic
        for (int i = 0; i < 150; i++) begin
            x = $urandom;
            y = $urandom;
            if (i % 5 == 0) y = ~x;
            cin = 1'($urandom_range(0, 1));
            sub = 1'b0;
`ifdef MWADD_SUB_EN
            sub = 1'($urandom_range(0, 1));
            bus.Sub = sub;
`endif
            expAdd = sub ? {x >= y, x - y} : 33'(x) + 33'(y) + 33'(cin);
            runOp(x, y, cin, s, co, lat);
            check($sformatf("rand[%0d] latency", i), lat, 5);
            check($sformatf("rand[%0d] result", i), {co, s}, expAdd);
        end
`ifdef MWADD_SUB_EN
        bus.Sub = 1'b0;
`endif

        // single-word instance
        @(negedge clock);
        bus1.X = 8'h80; bus1.Y = 8'h80; bus1.CarryIn = 1'b0; bus1.Start = 1'b1;
        @(negedge clock);
        bus1.Start = 1'b0;
        check("w1 Busy", bus1.Busy, 1);
        check("w1 early Done", bus1.Done, 0);
        @(negedge clock);
        check("w1 Done", bus1.Done, 1);
        check("w1 Sum", bus1.Sum, 8'h00);
        check("w1 CarryOut", bus1.CarryOut, 1);
        for (int i = 0; i < 20; i++) begin
            x8 = 8'($urandom);
            y8 = 8'($urandom);
            cin = 1'($urandom_range(0, 1));
            exp8 = 9'(x8) + 9'(y8) + 9'(cin);
            @(negedge clock);
            bus1.X = x8; bus1.Y = y8; bus1.CarryIn = cin; bus1.Start = 1'b1;
            @(negedge clock);
            bus1.Start = 1'b0;
            @(negedge clock);
            check($sformatf("w1 rand[%0d] Done", i), bus1.Done, 1);
            check($sformatf("w1 rand[%0d] result", i), {bus1.CarryOut, bus1.Sum}, exp8);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
